dxm_interrupt_service: RTL and testbench

Hardware interrupt servicer that sits on the consumer side of the `dxm_interrupt_low` status/mask register. It watches `int_req` and snapshots the unmasked pending bits. For each pending bit, lowest index first, it issues a one-cycle write-1-to-clear (`clr_status_1p` plus one-hot `r_din`), then delivers the bit index to a downstream engine over a valid/ready handshake. Its outputs drive the interrupt register's clear inputs directly, so hardware-only subsystems can drain interrupts without CPU involvement.

---
 rtl/dxm_interrupt_service_pkg.sv | 37 +++
 rtl/dxm_interrupt_service_if.sv | 46 ++++
 rtl/dxm_prio_enc_low.sv | 34 +++
 rtl/dxm_interrupt_service.sv | 188 ++++++++++++++++++
 tb/tb_dxm_interrupt_service.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dxm_interrupt_service_pkg.sv
// dxm_interrupt_service_pkg
// Shared definitions for the hardware interrupt servicer: the FSM state
// encoding, the fixed post-clear holdoff length and a ceiling-log2 helper
// used to size the event index.
// Ports: none (package).

package dxm_interrupt_service_pkg;

    // Servicer states. SAMPLE snapshots the pending bits, CLEAR pulses the
    // write-1-to-clear, DELIVER hands the index downstream and HOLDOFF lets
    // int_req catch up with the clears before we look at it again.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAMPLE  = 3'd1,
        ST_CLEAR   = 3'd2,
        ST_DELIVER = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    // int_req trails a clear by two cycles, so we idle this long after the
    // last event before trusting int_req again.
    localparam int HOLDOFF_CYC = 2;

    // Ceiling log2; callers only use it with values of 2 or more.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dxm_interrupt_service_if.sv
// dxm_interrupt_service_if
// Bundles the status-register side (int_req/status/mask in, clear strobe and
// one-hot clear vector out) and the downstream event handshake of the
// servicer.
// Parameters: VEC_W - width of status/mask/clear vectors.
// Modports:   master - the servicer; slave - status register + event sink.

interface dxm_interrupt_service_if
    import dxm_interrupt_service_pkg::*;
#(
    parameter int VEC_W = 8
);
    localparam int IDX_W = clog2(VEC_W);

    logic             int_req;
    logic [VEC_W-1:0] status;
    logic [VEC_W-1:0] mask;
    logic             clr_status_1p;
    logic [VEC_W-1:0] r_din;
    logic             evt_valid;
    logic [IDX_W-1:0] evt_idx;
    logic             evt_ready;

    modport master (
        input  int_req,
        input  status,
        input  mask,
        input  evt_ready,
        output clr_status_1p,
        output r_din,
        output evt_valid,
        output evt_idx
    );

    modport slave (
        output int_req,
        output status,
        output mask,
        output evt_ready,
        input  clr_status_1p,
        input  r_din,
        input  evt_valid,
        input  evt_idx
    );

endinterface

// File: rtl/dxm_prio_enc_low.sv
// dxm_prio_enc_low
// Combinational lowest-set-bit priority encoder.
// Ports: vec    - input vector
//        onehot - one-hot of the lowest set bit (0 if vec is 0)
//        idx    - index of the lowest set bit (0 if vec is 0)
//        any    - vec has at least one bit set

module dxm_prio_enc_low #(
    parameter int VEC_W = 8,
    parameter int IDX_W = 3
) (
    input  logic [VEC_W-1:0] vec,
    output logic [VEC_W-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the last hit, which overwrites the earlier
    // ones, is the lowest set bit.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = VEC_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dxm_interrupt_service.sv
// dxm_interrupt_service
// Drains a status/mask interrupt register in hardware: snapshots the unmasked
// pending bits, then for each one (lowest first) pulses a one-hot
// write-1-to-clear and delivers the bit index over a valid/ready handshake.
// Ports: clk, rst     - clock, asynchronous active-high reset
//        bus (master) - int_req/status/mask in, clr_status_1p/r_din out,
//                       evt_valid/evt_idx out, evt_ready in
//        busy         - FSM is not idle
//        timeout_err  - sticky, an event was dropped after TIMEOUT_CYC cycles
//        err_clr      - clears timeout_err (a simultaneous drop wins)

module dxm_interrupt_service
    import dxm_interrupt_service_pkg::*;
#(
    parameter int VEC_W       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    dxm_interrupt_service_if.master bus,
    output logic                    busy,
    output logic                    timeout_err,
    input  logic                    err_clr
);

    localparam int          IDX_W     = clog2(VEC_W);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYC - 1);
    localparam logic [1:0]  HOLD_LAST = 2'(HOLDOFF_CYC - 1);

    state_t           state_q, state_d;
    logic [VEC_W-1:0] snap_q, snap_d;
    logic [15:0]      tmo_cnt_q, tmo_cnt_d;
    logic [1:0]       hold_cnt_q, hold_cnt_d;
    logic             clr_q, clr_d;
    logic [VEC_W-1:0] rdin_q, rdin_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_d;
    logic             busy_d;

    logic [VEC_W-1:0] pend_src;
    logic [VEC_W-1:0] sel_onehot;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;
    logic             go_clear;
    logic             go_holdoff;
    logic             evt_done;
    logic             evt_drop;

    // The clear pulse and event index are registered outputs, so they are
    // loaded on the edge that enters CLEAR. Coming from SAMPLE that means the
    // select works on the live unmasked status (the same value snap takes);
    // coming from DELIVER it works on the remaining snapshot.
    assign pend_src = (state_q == ST_SAMPLE) ? (bus.status & ~bus.mask) : snap_q;

    dxm_prio_enc_low #(
        .VEC_W (VEC_W),
        .IDX_W (IDX_W)
    ) u_prio (
        .vec    (pend_src),
        .onehot (sel_onehot),
        .idx    (sel_idx),
        .any    (sel_any)
    );

    // Next-state and next-output logic. Each state only flags whether it
    // wants to move to CLEAR or HOLDOFF; the shared tail loads the clear
    // pulse, event index and trimmed snapshot, so SAMPLE and DELIVER treat a
    // new clear identically. A dropped event follows the accept path.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        tmo_cnt_d  = tmo_cnt_q;
        hold_cnt_d = hold_cnt_q;
        clr_d      = 1'b0;
        rdin_d     = '0;
        valid_d    = valid_q;
        idx_d      = idx_q;
        err_d      = timeout_err;
        go_clear   = 1'b0;
        go_holdoff = 1'b0;
        evt_done   = 1'b0;
        evt_drop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.int_req) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (sel_any) begin
                    go_clear = 1'b1;
                end else begin
                    go_holdoff = 1'b1;
                end
            end
            ST_CLEAR: begin
                state_d   = ST_DELIVER;
                valid_d   = 1'b1;
                tmo_cnt_d = '0;
            end
            ST_DELIVER: begin
                if (bus.evt_ready) begin
                    evt_done = 1'b1;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    evt_done = 1'b1;
                    evt_drop = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
                if (evt_done) begin
                    valid_d = 1'b0;
                    if (sel_any) begin
                        go_clear = 1'b1;
                    end else begin
                        go_holdoff = 1'b1;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_clear) begin
            state_d = ST_CLEAR;
            clr_d   = 1'b1;
            rdin_d  = sel_onehot;
            idx_d   = sel_idx;
            snap_d  = pend_src & ~sel_onehot;
        end
        if (go_holdoff) begin
            state_d    = ST_HOLDOFF;
            hold_cnt_d = '0;
            snap_d     = '0;
        end

        if (evt_drop) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers. Reset is asynchronous so an in-flight
    // clear pulse or event is withdrawn the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            snap_q      <= '0;
            tmo_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            clr_q       <= 1'b0;
            rdin_q      <= '0;
            valid_q     <= 1'b0;
            idx_q       <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            tmo_cnt_q   <= tmo_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            clr_q       <= clr_d;
            rdin_q      <= rdin_d;
            valid_q     <= valid_d;
            idx_q       <= idx_d;
            busy        <= busy_d;
            timeout_err <= err_d;
        end
    end

    assign bus.clr_status_1p = clr_q;
    assign bus.r_din         = rdin_q;
    assign bus.evt_valid     = valid_q;
    assign bus.evt_idx       = idx_q;

endmodule

// File: tb/tb_dxm_interrupt_service.sv
// tb_dxm_interrupt_service
// Scoreboard bench: stimulus pushes hand-computed clear vectors and event
// indices into queues, an independent monitor pops and compares them whenever
// the DUT pulses a clear or raises evt_valid. A small status-register model
// (write-1-to-clear, set wins, int_req lagging a clear by two cycles) feeds
// the DUT.

module tb_dxm_interrupt_service;

    localparam int VEC_W       = 8;
    localparam int TIMEOUT_CYC = 4;

    logic clk;
    logic rst;
    logic busy;
    logic timeout_err;
    logic err_clr;

    dxm_interrupt_service_if #(.VEC_W(VEC_W)) bus_if();

    dxm_interrupt_service #(
        .VEC_W       (VEC_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    int compares = 0;
    int fails    = 0;

    logic [7:0] exp_clr[$];
    logic [2:0] exp_evt[$];

    // Requests to the status model, each acknowledged by a changing id.
    logic [7:0] inject_val = 8'h00;
    int         inject_id  = 0;
    int         wipe_id    = 0;
    int         pulse_id   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compares++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Raise status bits as if events fired.
    task automatic applyStimulus(input logic [7:0] bits);
        tick();
        inject_val = bits;
        inject_id++;
    endtask

    task automatic pulseIrq();
        tick();
        pulse_id++;
    endtask

    task automatic wipeStatus();
        tick();
        wipe_id++;
        repeat (2) tick();
    endtask

    // Counts the cycles of the next busy period.
    task automatic measureBusy(input string name, input int expected);
        int n;
        int waited;
        n = 0;
        waited = 0;
        while (!busy && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!busy) begin
            checkOutput({name, "_start"}, 32'(busy), 32'd1);
            return;
        end
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        checkOutput(name, 32'(n), 32'(expected));
    endtask

    // Counts the cycles of the next evt_valid period.
    task automatic measureValid(input string name, input int expected);
        int n;
        int waited;
        n = 0;
        waited = 0;
        while (!bus_if.evt_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!bus_if.evt_valid) begin
            checkOutput({name, "_start"}, 32'(bus_if.evt_valid), 32'd1);
            return;
        end
        while (bus_if.evt_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput(name, 32'(n), 32'(expected));
    endtask

    task automatic waitIdle(input string name);
        int waited;
        waited = 0;
        @(negedge clk);
        while (busy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput(name, 32'(busy), 32'd0);
    endtask

    // Status register model: clears seen in a cycle take effect on the next
    // edge, injected events win over a same-cycle clear, int_req follows the
    // unmasked status with a one-register delay (two cycles after a clear).
    initial begin
        logic [7:0] clr_seen;
        logic       pend_q;
        int         inject_seen;
        int         wipe_seen;
        int         pulse_seen;
        pend_q         = 1'b0;
        inject_seen    = 0;
        wipe_seen      = 0;
        pulse_seen     = 0;
        bus_if.status  = 8'h00;
        bus_if.int_req = 1'b0;
        forever begin
            @(negedge clk);
            clr_seen = bus_if.clr_status_1p ? bus_if.r_din : 8'h00;
            @(posedge clk);
            #1;
            if (wipe_id != wipe_seen) begin
                wipe_seen      = wipe_id;
                bus_if.status  = 8'h00;
                bus_if.int_req = 1'b0;
                pend_q         = 1'b0;
            end else begin
                bus_if.status = bus_if.status & ~clr_seen;
                if (inject_id != inject_seen) begin
                    inject_seen   = inject_id;
                    bus_if.status = bus_if.status | inject_val;
                end
                bus_if.int_req = pend_q | (pulse_id != pulse_seen);
                pulse_seen     = pulse_id;
                pend_q         = |(bus_if.status & ~bus_if.mask);
            end
        end
    end

    // Monitor: pops expectations when the DUT presents a clear or an event,
    // and checks the pulse/valid/index invariants every cycle.
    initial begin
        logic       clr_q;
        logic       valid_q;
        logic [2:0] held_idx;
        clr_q    = 1'b0;
        valid_q  = 1'b0;
        held_idx = 3'd0;
        forever begin
            @(negedge clk);
            if (bus_if.clr_status_1p) begin
                checkOutput("clr_back_to_back", 32'(clr_q), 32'd0);
                if (exp_clr.size() == 0) begin
                    checkOutput("clr_unexpected", 32'(exp_clr.size()), 32'd1);
                end else begin
                    checkOutput("clr_r_din", 32'(bus_if.r_din), 32'(exp_clr.pop_front()));
                end
            end else begin
                checkOutput("r_din_idle", 32'(bus_if.r_din), 32'd0);
            end
            if (bus_if.evt_valid && !valid_q) begin
                if (exp_evt.size() == 0) begin
                    checkOutput("evt_unexpected", 32'(exp_evt.size()), 32'd1);
                end else begin
                    checkOutput("evt_idx", 32'(bus_if.evt_idx), 32'(exp_evt.pop_front()));
                end
                held_idx = bus_if.evt_idx;
            end else if (bus_if.evt_valid && valid_q) begin
                checkOutput("evt_idx_stable", 32'(bus_if.evt_idx), 32'(held_idx));
            end
            clr_q   = bus_if.clr_status_1p;
            valid_q = bus_if.evt_valid;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compares);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        rst              = 1'b1;
        err_clr          = 1'b0;
        bus_if.mask      = 8'h00;
        bus_if.evt_ready = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("rst_clr", 32'(bus_if.clr_status_1p), 32'd0);
        checkOutput("rst_r_din", 32'(bus_if.r_din), 32'd0);
        checkOutput("rst_evt_valid", 32'(bus_if.evt_valid), 32'd0);
        checkOutput("rst_evt_idx", 32'(bus_if.evt_idx), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        $display("[TB] two pending bits 8'h28, ready high");
        exp_clr.push_back(8'h08); exp_clr.push_back(8'h20);
        exp_evt.push_back(3'd3);  exp_evt.push_back(3'd5);
        applyStimulus(8'h28);
        measureBusy("busy_two_bits", 7);
        repeat (4) tick();

        $display("[TB] status 8'hFF with mask 8'hF0");
        tick();
        bus_if.mask = 8'hF0;
        for (int i = 0; i < 4; i++) begin
            exp_clr.push_back(8'(1 << i));
            exp_evt.push_back(3'(i));
        end
        applyStimulus(8'hFF);
        measureBusy("busy_masked", 11);
        repeat (4) tick();
        checkOutput("masked_bits_kept", 32'(bus_if.status), 32'hF0);
        checkOutput("no_err_yet", 32'(timeout_err), 32'd0);
        wipeStatus();
        bus_if.mask = 8'h00;
        repeat (2) tick();

        $display("[TB] timeout with ready held low");
        bus_if.evt_ready = 1'b0;
        exp_clr.push_back(8'h01); exp_clr.push_back(8'h02);
        exp_evt.push_back(3'd0);  exp_evt.push_back(3'd1);
        applyStimulus(8'h03);
        measureValid("valid_len_first", TIMEOUT_CYC);
        checkOutput("timeout_err_set", 32'(timeout_err), 32'd1);
        measureValid("valid_len_second", TIMEOUT_CYC);
        waitIdle("idle_after_timeout");
        checkOutput("timeout_err_sticky", 32'(timeout_err), 32'd1);
        bus_if.evt_ready = 1'b1;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        checkOutput("timeout_err_cleared", 32'(timeout_err), 32'd0);
        repeat (4) tick();

        $display("[TB] bit 2 re-set in the cycle it is cleared");
        exp_clr.push_back(8'h04); exp_clr.push_back(8'h04);
        exp_evt.push_back(3'd2);  exp_evt.push_back(3'd2);
        applyStimulus(8'h04);
        fork
            begin
                measureBusy("busy_pass1", 5);
                measureBusy("busy_pass2", 5);
            end
            begin : reinject
                int w;
                w = 0;
                while (!(bus_if.clr_status_1p && bus_if.r_din == 8'h04) && w < 40) begin
                    @(negedge clk);
                    w++;
                end
                checkOutput("reinject_seen", 32'(bus_if.clr_status_1p), 32'd1);
                inject_val = 8'h04;
                inject_id++;
            end
        join
        repeat (4) tick();

        $display("[TB] spurious int_req");
        bus_if.mask = 8'h10;
        applyStimulus(8'h10);
        repeat (3) tick();
        pulseIrq();
        measureBusy("busy_spurious", 3);
        wipeStatus();
        bus_if.mask = 8'h00;
        repeat (2) tick();

        $display("[TB] reset during DELIVER");
        bus_if.evt_ready = 1'b0;
        exp_clr.push_back(8'h01);
        exp_evt.push_back(3'd0);
        applyStimulus(8'h01);
        begin : wait_deliver
            int w;
            w = 0;
            while (!bus_if.evt_valid && w < 40) begin
                @(negedge clk);
                w++;
            end
        end
        checkOutput("deliver_reached", 32'(bus_if.evt_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_clr", 32'(bus_if.clr_status_1p), 32'd0);
        checkOutput("midrst_r_din", 32'(bus_if.r_din), 32'd0);
        checkOutput("midrst_evt_valid", 32'(bus_if.evt_valid), 32'd0);
        checkOutput("midrst_evt_idx", 32'(bus_if.evt_idx), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_timeout_err", 32'(timeout_err), 32'd0);
        repeat (2) @(negedge clk);
        tick();
        rst = 1'b0;
        bus_if.evt_ready = 1'b1;
        repeat (3) tick();
        exp_clr.push_back(8'h02);
        exp_evt.push_back(3'd1);
        applyStimulus(8'h02);
        measureBusy("busy_after_reset", 5);

        repeat (5) tick();
        checkOutput("exp_clr_left", 32'(exp_clr.size()), 32'd0);
        checkOutput("exp_evt_left", 32'(exp_evt.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
